ram_arbiter: RTL and testbench



---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/ram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM geometry and the arbiter FSM state type.
package ram_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 12;

    localparam int              GRANT_CNT_WIDTH = 16;
    localparam logic [15:0]     GRANT_CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } ram_arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester command bus, read return and RAM pin bundle.
// The master side is the client/RAM environment, the slave side is the arbiter.
interface ram_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH
);

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 gnt;
    logic [NUM_REQ-1:0]                 rvalid;
    logic [DATA_WIDTH-1:0]              rdata;
    logic                               cs;
    logic                               we;
    logic                               oe;
    logic [ADDR_WIDTH-1:0]              addr;
    logic [DATA_WIDTH-1:0]              data_in;
    logic [DATA_WIDTH-1:0]              data_out;
    logic [NUM_REQ-1:0][15:0]           grant_cnt;

    modport slave (
        input  req, req_we, req_addr, req_wdata, data_out,
        output gnt, rvalid, rdata, cs, we, oe, addr, data_in, grant_cnt
    );

    modport master (
        output req, req_we, req_addr, req_wdata, data_out,
        input  gnt, rvalid, rdata, cs, we, oe, addr, data_in, grant_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin priority pick. The search starts one past `last`
// and wraps; the result is one-hot, or zero when disabled or nothing requests.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt
);

    localparam int LW = $clog2(NUM_REQ);

    logic [LW:0]          shift;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   gnt_rot;

    // Rotate so that last+1 sits at bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        shift   = {1'b0, last} + (LW+1)'(1);
        req_rot = NUM_REQ'({req, req} >> shift);
        gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
        gnt     = en ? NUM_REQ'(({gnt_rot, gnt_rot} << shift) >> NUM_REQ) : '0;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between NUM_REQ requesters.
// Commands are accepted round-robin, replayed on the registered RAM pins for
// one cycle, and reads return data_out one cycle later with an rvalid strobe.
// Addresses at or beyond DEPTH walk the same states without asserting cs.
// Optional feature: define RAM_ARB_PERF_EN for saturating per-requester
// grant counters; otherwise grant_cnt is tied to zero.
module ram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int DEPTH      = ram_pkg::DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);

    import ram_pkg::*;

    localparam int                  LW        = $clog2(NUM_REQ);
    localparam logic [LW-1:0]       LAST_RST  = LW'(NUM_REQ - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    ram_arb_state_e        state_q, state_d;
    logic [LW-1:0]         last_q, last_d;
    logic                  oor_q, oor_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;

    logic                  arb_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [LW-1:0]         win_idx;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_in_range;

    // Grants are offered only while idle and never while reset is asserted.
    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req  (bus.req),
        .last (last_q),
        .en   (arb_en),
        .gnt  (gnt)
    );

    assign bus.gnt = gnt;

    // Select the winning requester's command fields from the one-hot grant.
    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx   = LW'(i);
                win_we    = bus.req_we[i];
                win_addr  = bus.req_addr[i];
                win_wdata = bus.req_wdata[i];
            end
        end
        win_in_range = ({1'b0, win_addr} < DEPTH_LIM);
    end

    // Next state and next RAM pin values; pins are idle unless entering ACCESS.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        oor_d     = oor_q;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        oe_d      = 1'b0;
        addr_d    = '0;
        data_in_d = '0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d   = ACCESS;
                    last_d    = win_idx;
                    oor_d     = !win_in_range;
                    cs_d      = win_in_range;
                    we_d      = win_we;
                    oe_d      = !win_we;
                    addr_d    = win_addr;
                    data_in_d = win_wdata;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LAST_RST;
            oor_q     <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            oor_q     <= oor_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            data_in_q <= data_in_d;
        end
    end

    assign bus.cs      = cs_q;
    assign bus.we      = we_q;
    assign bus.oe      = oe_q;
    assign bus.addr    = addr_q;
    assign bus.data_in = data_in_q;

    // Read return: the owner is the last granted requester; out-of-range reads give zero.
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        if (state_q == RESP) begin
            bus.rvalid = {{(NUM_REQ-1){1'b0}}, 1'b1} << last_q;
            if (!oor_q) begin
                bus.rdata = bus.data_out;
            end
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [NUM_REQ-1:0][GRANT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of grants per requester.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (cnt_q[i] != GRANT_CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.grant_cnt = cnt_q;
`else
    assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized command streams for two requesters,
// checked cycle by cycle against a transaction-level timeline model.
module tb_ram_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DP = 12;
`ifdef RAM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM: samples pins on the rising edge that ends ACCESS.
    logic [DW-1:0] ram_arr [16];
    always @(posedge clk) begin
        if (bus.cs) begin
            if (bus.we) ram_arr[bus.addr] <= bus.data_in;
            else        bus.data_out     <= ram_arr[bus.addr];
        end
    end

    int checks;
    int errors;

    // Reference model state
    cmd_t          cq [NR][$];
    cmd_t          pend [NR];
    bit            pend_v [NR];
    logic [DW-1:0] mem [16];
    int            cyc, next_free, acc_cyc, resp_cyc, resp_owner, m_last;
    int            m_cnt [NR];
    cmd_t          acc_cmd;
    logic [DW-1:0] resp_data;
    logic [NR-1:0] obs_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic we, input int a, input int d);
        cmd_t c;
        c.we   = we;
        c.addr = a[AW-1:0];
        c.data = d[DW-1:0];
        return c;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        next_free = 0;
        acc_cyc   = -1;
        resp_cyc  = -1;
        m_last    = NR - 1;
        for (int i = 0; i < NR; i++) begin
            m_cnt[i]  = 0;
            pend_v[i] = 1'b0;
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (cyc < next_free);
        for (int i = 0; i < NR; i++) b = b || pend_v[i] || (cq[i].size() > 0);
        return b;
    endfunction

    // One clock cycle: drive requests, check every output against the model, commit the grant.
    task automatic cycle();
        logic [NR-1:0] exp_gnt;
        int win;
        int cand;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (!pend_v[i] && cq[i].size() > 0) begin
                pend[i]   = cq[i].pop_front();
                pend_v[i] = 1'b1;
            end
            bus.req[i]       = pend_v[i];
            bus.req_we[i]    = pend[i].we;
            bus.req_addr[i]  = pend[i].addr;
            bus.req_wdata[i] = pend[i].data;
        end
        #1;
        exp_gnt = '0;
        win     = -1;
        if (cyc >= next_free) begin
            for (int k = 1; k <= NR; k++) begin
                cand = (m_last + k) % NR;
                if (win < 0 && pend_v[cand]) win = cand;
            end
        end
        if (win >= 0) exp_gnt[win] = 1'b1;
        obs_gnt = bus.gnt;
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("cs", 32'(bus.cs), 32'((cyc == acc_cyc) && (int'(acc_cmd.addr) < DP)));
        if (cyc == acc_cyc) begin
            check("we", 32'(bus.we), 32'(acc_cmd.we));
            check("oe", 32'(bus.oe), 32'(!acc_cmd.we));
            check("addr", 32'(bus.addr), 32'(acc_cmd.addr));
            check("data_in", 32'(bus.data_in), 32'(acc_cmd.data));
        end
        check("rvalid", 32'(bus.rvalid), (cyc == resp_cyc) ? (32'd1 << resp_owner) : 32'd0);
        check("rdata", 32'(bus.rdata), (cyc == resp_cyc) ? 32'(resp_data) : 32'd0);
        if (win >= 0) begin
            m_last       = win;
            m_cnt[win]++;
            acc_cyc      = cyc + 1;
            acc_cmd      = pend[win];
            pend_v[win]  = 1'b0;
            if (acc_cmd.we) begin
                if (int'(acc_cmd.addr) < DP) mem[acc_cmd.addr] = acc_cmd.data;
                next_free = cyc + 2;
            end else begin
                resp_cyc   = cyc + 2;
                resp_owner = win;
                resp_data  = (int'(acc_cmd.addr) < DP) ? mem[acc_cmd.addr] : '0;
                next_free  = cyc + 3;
            end
        end
        cyc++;
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        check("run_timeout", 32'(busy()), 32'd0);
        for (int i = 0; i < NR; i++) begin
            check("grant_cnt", 32'(bus.grant_cnt[i]), PERF ? 32'(m_cnt[i]) : 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"}, 32'(bus.cs), 32'd0);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_oe"}, 32'(bus.oe), 32'd0);
        check({tag, "_addr"}, 32'(bus.addr), 32'd0);
        check({tag, "_data_in"}, 32'(bus.data_in), 32'd0);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        check({tag, "_cnt0"}, 32'(bus.grant_cnt[0]), 32'd0);
        check({tag, "_cnt1"}, 32'(bus.grant_cnt[1]), 32'd0);
    endtask

    initial begin
        int r;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < NR; i++) pend[i] = '0;
        model_reset();

        // Reset state, with both requesters asking: no grant while in reset
        bus.req = 2'b11;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single write then read on requester 0
        cq[0].push_back(mk(1'b1, 3, 8'h5A));
        cq[0].push_back(mk(1'b0, 3, 0));
        run(40);

        // Fill and dump on requester 1
        for (int i = 0; i < DP; i++) cq[1].push_back(mk(1'b1, i, i + 1));
        for (int i = 0; i < DP; i++) cq[1].push_back(mk(1'b0, i, 0));
        run(200);

        // Conflicting continuous reads
        for (int k = 0; k < 4; k++) begin
            cq[0].push_back(mk(1'b0, k, 0));
            cq[1].push_back(mk(1'b0, k + 4, 0));
        end
        run(100);

        // Out-of-range write and read
        cq[0].push_back(mk(1'b1, 13, 8'hFF));
        cq[0].push_back(mk(1'b0, 13, 0));
        run(40);

        // Randomized mixed traffic, including out-of-range addresses
        repeat (3) begin
            repeat (12) begin
                r = int'($urandom_range(0, NR - 1));
                cq[r].push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                                   int'($urandom_range(0, 255))));
            end
            run(300);
        end

        // Reset asserted during ACCESS of a read
        cq[0].push_back(mk(1'b0, 3, 0));
        cycle();
        cycle();
        #2;
        rst_n   = 1'b0;
        bus.req = 2'b11;
        #1;
        check_all_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_hold_rvalid", 32'(bus.rvalid), 32'd0);
            check("rst_hold_gnt", 32'(bus.gnt), 32'd0);
        end
        model_reset();
        bus.req = '0;
        rst_n   = 1'b1;
        cq[1].push_back(mk(1'b0, 5, 0));
        cq[0].push_back(mk(1'b0, 6, 0));
        cycle();
        check("first_gnt_after_reset", 32'(obs_gnt), 32'd1);
        run(50);

        // Grant counters: 5 grants to requester 0, 3 to requester 1 after a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cq[0].push_back(mk(1'b1, i, 8'h10 + i));
        for (int i = 0; i < 3; i++) cq[1].push_back(mk(1'b1, i + 6, 8'h20 + i));
        run(100);
        check("perf_cnt0", 32'(bus.grant_cnt[0]), PERF ? 32'd5 : 32'd0);
        check("perf_cnt1", 32'(bus.grant_cnt[1]), PERF ? 32'd3 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
